// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and the read-side packing factor for the channel FIFO bank.
package fifo_pkg;
    localparam int PACK = 2;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction
endpackage

// File: rtl/sync_fifo_ch.sv
// sync_fifo_ch: one channel buffer with single-word push and two-word pop.
module sync_fifo_ch #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADD_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  push,
    input  logic                  pop2,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [ADD_WIDTH:0]    count,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADD_WIDTH-1:0]  wr_q, rd_q, rd_nx;
    logic [ADD_WIDTH:0]    cnt_q, cnt_d;
    logic                  ovf_q, do_push;

    assign full    = cnt_q == (ADD_WIDTH+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign ovf     = ovf_q;
    assign do_push = push && !full;
    assign rd_nx   = rd_q + ADD_WIDTH'(1);
    assign lo      = mem_q[rd_q];
    assign hi      = mem_q[rd_nx];
    // Pop is only granted at count>=2, so the subtraction never underflows.
    assign cnt_d   = cnt_q + (ADD_WIDTH+1)'(do_push) - (pop2 ? (ADD_WIDTH+1)'(2) : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + ADD_WIDTH'(1);
            if (pop2) rd_q <= rd_q + ADD_WIDTH'(2);
            if (push && full) ovf_q <= 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/multi_ch_l2h_fifo.sv
// multi_ch_l2h_fifo: N-channel FIFO bank packing word pairs from a round-robin
// selected channel into a double-width valid/ready output register.
module multi_ch_l2h_fifo import fifo_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADD_WIDTH  = clog2(DEPTH),
    parameter int NUM_CH     = 2,
    parameter int CH_WIDTH   = ch_width(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       wen,
    input  logic [CH_WIDTH-1:0]        wch,
    input  logic                       ren,
    output logic [PACK*DATA_WIDTH-1:0] dout,
    output logic [CH_WIDTH-1:0]        dout_ch,
    output logic                       dout_valid,
    output logic                       lh,
    output logic [NUM_CH-1:0]          full,
    output logic [NUM_CH-1:0]          empty,
    output logic [NUM_CH-1:0]          ovf
);
    logic [DATA_WIDTH-1:0]      lo [NUM_CH];
    logic [DATA_WIDTH-1:0]      hi [NUM_CH];
    logic [ADD_WIDTH:0]         cnt [NUM_CH];
    logic [NUM_CH-1:0]          elig, pop;
    logic [CH_WIDTH-1:0]        rr_last_q, grant;
    logic [PACK*DATA_WIDTH-1:0] dout_q;
    logic [CH_WIDTH-1:0]        dout_ch_q;
    logic                       dout_valid_q, lh_q, found, load;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sync_fifo_ch #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH),
            .ADD_WIDTH (ADD_WIDTH)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .din  (din),
            .push (wen && wch == CH_WIDTH'(i)),
            .pop2 (pop[i]),
            .lo   (lo[i]),
            .hi   (hi[i]),
            .count(cnt[i]),
            .full (full[i]),
            .empty(empty[i]),
            .ovf  (ovf[i])
        );
        assign elig[i] = cnt[i] >= (ADD_WIDTH+1)'(2);
        assign pop[i]  = load && grant == CH_WIDTH'(i);
    end

    // Scan from the farthest candidate down so the nearest eligible one after rr_last wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (elig[(int'(rr_last_q) + k) % NUM_CH]) begin
                grant = CH_WIDTH'((int'(rr_last_q) + k) % NUM_CH);
                found = 1'b1;
            end
        end
    end

    assign load       = (!dout_valid_q || ren) && found;
    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;
    assign lh         = lh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            lh_q         <= 1'b0;
            rr_last_q    <= CH_WIDTH'(NUM_CH - 1);
        end else begin
            lh_q <= load;
            if (load) begin
                dout_q       <= {hi[grant], lo[grant]};
                dout_ch_q    <= grant;
                dout_valid_q <= 1'b1;
                rr_last_q    <= grant;
            end else if (ren) begin
                dout_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_multi_ch_l2h_fifo.sv
// tb_multi_ch_l2h_fifo: directed stimulus with a scoreboard of expected packed words
// and a monitor that checks every word as it loads into the output register.
module tb_multi_ch_l2h_fifo;
    logic        clk = 1'b0, rst = 1'b1, wen = 1'b0, wch = 1'b0, ren = 1'b0;
    logic [7:0]  din = '0;
    logic [15:0] dout;
    logic        dout_ch, dout_valid, lh;
    logic [1:0]  full, empty, ovf;
    logic [16:0] sb [$];
    logic [16:0] mon_exp;
    int          compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    multi_ch_l2h_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ADD_WIDTH(3), .NUM_CH(2), .CH_WIDTH(1)) dut (
        .clk(clk), .rst(rst), .din(din), .wen(wen), .wch(wch), .ren(ren),
        .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .lh(lh),
        .full(full), .empty(empty), .ovf(ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic ch, input logic [7:0] d);
        wen = 1'b1;
        wch = ch;
        din = d;
        step(1);
        wen = 1'b0;
    endtask

    task automatic expect_word(input logic ch, input logic [15:0] d);
        sb.push_back({ch, d});
    endtask

    always @(negedge clk) begin
        if (lh) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_word: got ch%0d %h expected no word", dout_ch, dout);
            end else begin
                mon_exp = sb.pop_front();
                if ({dout_ch, dout} !== mon_exp) begin
                    mismatched++;
                    $display("FAIL packed_word: got ch%0d %h expected ch%0d %h",
                             dout_ch, dout, mon_exp[16], mon_exp[15:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        step(2);
        rst = 1'b0;
        chk("por_valid", 32'(dout_valid), 32'd0);
        chk("por_empty", 32'(empty), 32'h3);
        chk("por_ovf", 32'(ovf), 32'd0);

        // reset in the middle of traffic
        expect_word(1'b0, 16'hC2C1);
        wr(1'b0, 8'hC1);
        wr(1'b0, 8'hC2);
        wr(1'b0, 8'h77);
        wr(1'b1, 8'h88);
        rst = 1'b1;
        wen = 1'b1; wch = 1'b1; din = 8'h99;
        step(2);
        rst = 1'b0;
        wen = 1'b0;
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_lh", 32'(lh), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_empty", 32'(empty), 32'h3);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // single pair, ready held high
        ren = 1'b1;
        expect_word(1'b0, 16'h2211);
        wr(1'b0, 8'h11);
        wr(1'b0, 8'h22);
        step(1);
        chk("pair_dout", 32'(dout), 32'h2211);
        chk("pair_ch", 32'(dout_ch), 32'd0);
        chk("pair_valid", 32'(dout_valid), 32'd1);
        chk("pair_lh", 32'(lh), 32'd1);
        chk("pair_empty0", 32'(empty[0]), 32'd1);
        step(1);
        chk("pair_lh_drop", 32'(lh), 32'd0);
        chk("pair_valid_drop", 32'(dout_valid), 32'd0);

        // round-robin between two preloaded channels
        ren = 1'b0;
        expect_word(1'b0, 16'hA1A0);
        expect_word(1'b1, 16'hB1B0);
        expect_word(1'b0, 16'hA3A2);
        expect_word(1'b1, 16'hB3B2);
        for (int i = 0; i < 4; i++) wr(1'b0, 8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) wr(1'b1, 8'hB0 + 8'(i));
        chk("rr_first", 32'(dout), 32'hA1A0);
        ren = 1'b1;
        step(5);
        chk("rr_empty", 32'(empty), 32'h3);
        chk("rr_valid", 32'(dout_valid), 32'd0);

        // fill channel 1 past full behind a stalled output
        ren = 1'b0;
        expect_word(1'b0, 16'h3231);
        wr(1'b0, 8'h31);
        wr(1'b0, 8'h32);
        for (int i = 1; i <= 8; i++) wr(1'b1, 8'(i));
        chk("fill_full", 32'(full), 32'h2);
        chk("fill_ovf_clear", 32'(ovf), 32'd0);
        chk("fill_hold", 32'(dout), 32'h3231);
        wr(1'b1, 8'h09);
        chk("ovf_set", 32'(ovf), 32'h2);
        chk("ovf_full", 32'(full), 32'h2);
        expect_word(1'b1, 16'h0201);
        expect_word(1'b1, 16'h0403);
        expect_word(1'b1, 16'h0605);
        expect_word(1'b1, 16'h0807);
        ren = 1'b1;
        step(6);
        chk("ovf_sticky", 32'(ovf), 32'h2);
        chk("drain_empty", 32'(empty), 32'h3);
        chk("drain_full", 32'(full), 32'd0);

        // backpressure holds the output register
        ren = 1'b0;
        expect_word(1'b0, 16'h4241);
        expect_word(1'b0, 16'h4443);
        wr(1'b0, 8'h41);
        wr(1'b0, 8'h42);
        wr(1'b0, 8'h43);
        wr(1'b0, 8'h44);
        for (int i = 0; i < 5; i++) begin
            chk("hold_dout", 32'(dout), 32'h4241);
            chk("hold_ch", 32'(dout_ch), 32'd0);
            chk("hold_lh", 32'(lh), 32'd0);
            chk("hold_empty", 32'(empty), 32'h2);
            step(1);
        end
        ren = 1'b1;
        step(1);
        chk("release_dout", 32'(dout), 32'h4443);
        chk("release_lh", 32'(lh), 32'd1);
        chk("release_empty", 32'(empty), 32'h3);
        step(2);

        // odd word waits for its partner; write and pop on one edge
        wr(1'b0, 8'h5A);
        chk("odd_valid", 32'(dout_valid), 32'd0);
        chk("odd_empty", 32'(empty), 32'h2);
        step(1);
        chk("odd_still", 32'(dout_valid), 32'd0);
        expect_word(1'b0, 16'h5B5A);
        wr(1'b0, 8'h5B);
        step(1);
        chk("partner_dout", 32'(dout), 32'h5B5A);
        chk("partner_lh", 32'(lh), 32'd1);
        expect_word(1'b0, 16'h6261);
        wr(1'b0, 8'h61);
        wr(1'b0, 8'h62);
        wr(1'b0, 8'h63);
        chk("wrpop_dout", 32'(dout), 32'h6261);
        chk("wrpop_empty", 32'(empty), 32'h2);
        step(1);
        chk("wrpop_no_load", 32'(dout_valid), 32'd0);
        chk("wrpop_count1", 32'(empty), 32'h2);
        expect_word(1'b0, 16'h6463);
        wr(1'b0, 8'h64);
        step(1);
        chk("wrpop_next", 32'(dout), 32'h6463);
        chk("final_empty", 32'(empty), 32'h3);

        step(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
